cpu_boot_sequencer: RTL and testbench

- Sequences CPU start-up.
- Holds the CPU pipeline in reset while a program image streams in over a byte-wide valid/ready link, normally from the UART receiver.
- Assembles little-endian 32-bit words and writes them into instruction/data RAM through a write port using the CPU's 4-bit byte-enable convention.
- Releases the CPU reset once the image has been written, so the CPU begins fetching at PC 0.

---
 rtl/cpu_boot_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cpu_boot_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer: holds the CPU in reset while a program image arrives
// as a byte stream (32-bit little-endian length header, then data words),
// writes each assembled word to instruction/data RAM and then releases the
// CPU reset so it starts fetching at PC 0.
// Optional feature: define CPU_BOOT_CHECKSUM_EN to require a trailing
// 32-bit modular sum of the data words before the CPU is released.
module cpu_boot_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        boot_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wenable,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_LEN = MAX_WORDS;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef CPU_BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] word_idx;
  logic [31:0] len;
  logic [31:0] shift;
  logic [31:0] full;
  logic        accept;
  logic        last_byte;
`ifdef CPU_BOOT_CHECKSUM_EN
  logic [31:0] sum;
`endif

  assign accept    = rx_valid & rx_ready;
  // New bytes enter at the top, so after four shifts the first byte sits in [7:0].
  assign full      = {rx_data, shift[31:8]};
  assign last_byte = accept && (byte_cnt == 2'd3);

  // Byte assembly and length capture (datapath, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) shift <= full;
    if (last_byte && state == S_LEN) len <= full;
  end

  // Boot FSM with registered handshake, RAM write port and CPU control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LEN;
      byte_cnt    <= 2'd0;
      word_idx    <= 32'd0;
      rx_ready    <= 1'b0;
      mem_wenable <= 4'b0000;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= 32'd0;
      cpu_rst_n   <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef CPU_BOOT_CHECKSUM_EN
      sum         <= 32'd0;
`endif
    end else begin
      if (accept) byte_cnt <= byte_cnt + 2'd1;
      case (state)
        S_LEN: begin
          rx_ready <= 1'b1;
          if (last_byte) begin
            word_idx <= 32'd0;
`ifdef CPU_BOOT_CHECKSUM_EN
            sum      <= 32'd0;
`endif
            if (full > MAX_LEN) begin
              state    <= S_ERROR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else if (full == 32'd0) begin
`ifdef CPU_BOOT_CHECKSUM_EN
              state     <= S_CSUM;
`else
              state     <= S_RUN;
              rx_ready  <= 1'b0;
              cpu_rst_n <= 1'b1;
              done      <= 1'b1;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (last_byte) begin
            state       <= S_WRITE;
            rx_ready    <= 1'b0;
            mem_wenable <= 4'b1111;
            mem_addr    <= BASE_ADDR + (word_idx << 2);
            mem_wdata   <= full;
          end
        end
        S_WRITE: begin
          mem_wenable <= 4'b0000;
          word_idx    <= word_idx + 32'd1;
`ifdef CPU_BOOT_CHECKSUM_EN
          sum         <= sum + mem_wdata;
`endif
          if (word_idx + 32'd1 == len) begin
`ifdef CPU_BOOT_CHECKSUM_EN
            state     <= S_CSUM;
            rx_ready  <= 1'b1;
`else
            // Write enable drops on this same edge, so the CPU never runs during a write.
            state     <= S_RUN;
            cpu_rst_n <= 1'b1;
            done      <= 1'b1;
`endif
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end
`ifdef CPU_BOOT_CHECKSUM_EN
        S_CSUM: begin
          if (last_byte) begin
            rx_ready <= 1'b0;
            if (full == sum) begin
              state     <= S_RUN;
              cpu_rst_n <= 1'b1;
              done      <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        S_RUN: begin
          if (boot_req) begin
            state     <= S_LEN;
            rx_ready  <= 1'b1;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            word_idx  <= 32'd0;
            byte_cnt  <= 2'd0;
          end
        end
        S_ERROR: begin
          if (boot_req) begin
            state    <= S_LEN;
            rx_ready <= 1'b1;
            error    <= 1'b0;
            word_idx <= 32'd0;
            byte_cnt <= 2'd0;
          end
        end
        default: begin
          state    <= S_LEN;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed testbench for cpu_boot_sequencer: reset values, multi-word loads,
// oversize header, reset mid-load, reboot with gaps, and (when
// CPU_BOOT_CHECKSUM_EN is defined) checksum accept/reject.
module tb_cpu_boot_sequencer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        boot_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wenable;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];

  cpu_boot_sequencer #(.BASE_ADDR(BASE), .MAX_WORDS(4096)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .boot_req(boot_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wenable(mem_wenable), .cpu_rst_n(cpu_rst_n),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Write monitor: every write must be a full-word write with the CPU held
  // in reset and no byte being accepted; log it for comparison.
  always @(posedge clk) begin
    #1;
    if (mem_wenable !== 4'b0000) begin
      check("wr_enable", {28'd0, mem_wenable}, 32'h0000_000F);
      check("wr_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("wr_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      wr_q.push_back({mem_addr, mem_wdata});
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "global timeout");
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", {31'd0, (n >= 40)}, 32'd0);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) send_byte(t[8*i +: 8]);
  endtask

  task automatic finish_image(input logic [31:0] csum);
`ifdef CPU_BOOT_CHECKSUM_EN
    send_word(csum);
`else
    if (csum == 32'hFFFF_FFFF) $display("note: checksum word not sent");
`endif
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    rx_valid = 1'b0;
    while (!done && !error && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("end_wait", {31'd0, (n >= 20)}, 32'd0);
  endtask

  task automatic pulse_boot();
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_count"}, wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, wr_q[i][63:32], exp_q[i][63:32]);
      check({tag, "_data"}, wr_q[i][31:0], exp_q[i][31:0]);
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; boot_req = 1'b0;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wenable", {28'd0, mem_wenable}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("post_rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
    check("post_rst_error", {31'd0, error}, 32'd0);
    check("post_rst_wenable", {28'd0, mem_wenable}, 32'd0);
    @(negedge clk);

    // Two-word load, bytes back-to-back
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
`ifdef CPU_BOOT_CHECKSUM_EN
    finish_image(32'h0000_0082);
    wait_end();
`else
    rx_valid = 1'b0;
    check("two_word_in_write_cpu", {31'd0, cpu_rst_n}, 32'd0);
    @(posedge clk); #1;
    check("two_word_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    check("two_word_done", {31'd0, done}, 32'd1);
    @(negedge clk);
`endif
    check("two_word_done_final", {31'd0, done}, 32'd1);
    exp_q.push_back({BASE, 32'h0000_0013});
    exp_q.push_back({BASE + 32'd4, 32'h0000_006F});
    check_writes("two_word");
    // Bytes offered in RUN are ignored
    rx_data = 8'h99; rx_valid = 1'b1;
    @(negedge clk);
    check("run_rx_ready", {31'd0, rx_ready}, 32'd0);
    rx_valid = 1'b0;

    // Oversize header, then recovery
    pulse_boot();
    send_word(32'd4097);
    rx_valid = 1'b0;
    @(negedge clk);
    check("oversize_error", {31'd0, error}, 32'd1);
    check("oversize_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("oversize_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_writes("oversize");
    pulse_boot();
    check("recover_error_clr", {31'd0, error}, 32'd0);
    send_word(32'd1);
    send_word(32'hDDCC_BBAA);
    finish_image(32'hDDCC_BBAA);
    wait_end();
    check("recover_done", {31'd0, done}, 32'd1);
    check("recover_error", {31'd0, error}, 32'd0);
    exp_q.push_back({BASE, 32'hDDCC_BBAA});
    check_writes("recover");

    // Reset after 6 bytes of a 2-word image, then a fresh 1-word image
    pulse_boot();
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    finish_image(32'hDEAD_BEEF);
    wait_end();
    check("midrst_done", {31'd0, done}, 32'd1);
    exp_q.push_back({BASE, 32'hDEAD_BEEF});
    check_writes("midrst");

    // Reboot with a simultaneous byte, then a gapped image
    boot_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1;
    check("reboot_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("reboot_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    boot_req = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b0;
      repeat (i % 4) @(negedge clk);
      send_byte((i == 0) ? 8'h01 : 8'h00);
    end
    // boot_req while loading must be ignored
    rx_valid = 1'b0; boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b0;
      repeat (3 - i) @(negedge clk);
      send_byte(8'h78 - 8'(i * 8'h22));
    end
    finish_image(32'h1234_5678);
    wait_end();
    check("gap_done", {31'd0, done}, 32'd1);
    check("gap_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    exp_q.push_back({BASE, 32'h1234_5678});
    check_writes("gap");

    // Empty image
    pulse_boot();
    send_word(32'd0);
    finish_image(32'd0);
    wait_end();
    check("empty_done", {31'd0, done}, 32'd1);
    check_writes("empty");

`ifdef CPU_BOOT_CHECKSUM_EN
    // Checksum match: 1 + FFFFFFFF wraps to 0
    pulse_boot();
    send_word(32'd2);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    finish_image(32'h0000_0000);
    wait_end();
    check("csum_ok_done", {31'd0, done}, 32'd1);
    check("csum_ok_error", {31'd0, error}, 32'd0);
    exp_q.push_back({BASE, 32'h0000_0001});
    exp_q.push_back({BASE + 32'd4, 32'hFFFF_FFFF});
    check_writes("csum_ok");
    // Checksum mismatch
    pulse_boot();
    send_word(32'd2);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    finish_image(32'h0000_0001);
    wait_end();
    check("csum_bad_error", {31'd0, error}, 32'd1);
    check("csum_bad_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("csum_bad_done", {31'd0, done}, 32'd0);
    exp_q.push_back({BASE, 32'h0000_0001});
    exp_q.push_back({BASE + 32'd4, 32'hFFFF_FFFF});
    check_writes("csum_bad");
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
